// File: rtl/ctf_turn_ctrl_pkg.sv
// Shared constants for the capture-the-flag turn controller: board size,
// direction codes, start/goal cells, winner codes and FSM state encoding.
package ctf_turn_ctrl_pkg;

    localparam int GRID = 10;

    localparam logic [1:0] DIR_UP = 2'd0;  // y-1
    localparam logic [1:0] DIR_DN = 2'd1;  // y+1
    localparam logic [1:0] DIR_LT = 2'd2;  // x-1
    localparam logic [1:0] DIR_RT = 2'd3;  // x+1

    localparam logic [3:0] P1_START_X = 4'd0;
    localparam logic [3:0] P1_START_Y = 4'd0;
    localparam logic [3:0] P1_GOAL_X  = 4'd9;
    localparam logic [3:0] P1_GOAL_Y  = 4'd9;
    localparam logic [3:0] P2_START_X = 4'd9;
    localparam logic [3:0] P2_START_Y = 4'd9;
    localparam logic [3:0] P2_GOAL_X  = 4'd0;
    localparam logic [3:0] P2_GOAL_Y  = 4'd0;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TURN       = 3'd1,
        ST_CHECK      = 3'd2,
        ST_WAIT_FRAME = 3'd3,
        ST_COMMIT     = 3'd4,
        ST_WON        = 3'd5
    } state_t;

endpackage

// File: rtl/ctf_turn_ctrl_if.sv
// Move-request handshake for both players. The player side drives
// valid/dir and watches ready; the controller side grants ready.
interface ctf_turn_ctrl_if;

    logic       p1_valid;
    logic [1:0] p1_dir;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_dir;
    logic       p2_ready;

    modport master (
        output p1_valid, p1_dir, p2_valid, p2_dir,
        input  p1_ready, p2_ready
    );

    modport slave (
        input  p1_valid, p1_dir, p2_valid, p2_dir,
        output p1_ready, p2_ready
    );

endinterface

// File: rtl/ctf_turn_ctrl_move_check.sv
// Combinational legality check for one move: target cell from position and
// direction, then board bounds, wall bitmap and opponent collision.
module ctf_turn_ctrl_move_check
    import ctf_turn_ctrl_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [3:0] pos_x,
    input  logic [3:0] pos_y,
    input  logic [1:0] dir,
    input  logic [3:0] opp_x,
    input  logic [3:0] opp_y,
    input  logic [N:0] row1,
    input  logic [N:0] row2,
    input  logic [N:0] row3,
    input  logic [N:0] row4,
    input  logic [N:0] row5,
    input  logic [N:0] row6,
    input  logic [N:0] row7,
    input  logic [N:0] row8,
    input  logic [N:0] row9,
    input  logic [N:0] row10,
    output logic [3:0] tgt_x,
    output logic [3:0] tgt_y,
    output logic       legal
);

    // 5 bits so that 0-1 wraps to 31 and 9+1 gives 10; both fail the bound test
    logic [4:0]  nx;
    logic [4:0]  ny;
    logic [N:0]  row_sel;
    logic [15:0] row_ext;
    logic        on_board;
    logic        wall_hit;
    logic        opp_hit;

    // target cell
    always_comb begin
        nx = {1'b0, pos_x};
        ny = {1'b0, pos_y};
        case (dir)
            DIR_UP:  ny = {1'b0, pos_y} - 5'd1;
            DIR_DN:  ny = {1'b0, pos_y} + 5'd1;
            DIR_LT:  nx = {1'b0, pos_x} - 5'd1;
            default: nx = {1'b0, pos_x} + 5'd1;
        endcase
    end

    // wall row selected by the target row
    always_comb begin
        row_sel = '0;
        case (ny)
            5'd0:    row_sel = row1;
            5'd1:    row_sel = row2;
            5'd2:    row_sel = row3;
            5'd3:    row_sel = row4;
            5'd4:    row_sel = row5;
            5'd5:    row_sel = row6;
            5'd6:    row_sel = row7;
            5'd7:    row_sel = row8;
            5'd8:    row_sel = row9;
            5'd9:    row_sel = row10;
            default: row_sel = '0;
        endcase
    end

    assign row_ext  = 16'(row_sel);
    assign on_board = (nx < 5'(GRID)) && (ny < 5'(GRID));
    assign wall_hit = row_ext[nx[3:0]];
    assign opp_hit  = (nx[3:0] == opp_x) && (ny[3:0] == opp_y);
    assign legal    = on_board && !wall_hit && !opp_hit;
    assign tgt_x    = nx[3:0];
    assign tgt_y    = ny[3:0];

endmodule

// File: rtl/ctf_turn_ctrl.sv
// Turn scheduler and move sequencer for the 10x10 capture-the-flag board.
// One request per turn is accepted, checked, then committed on a frame
// boundary so the renderer never sees a position change mid-frame.
//
//  state       | meaning
//  ------------+--------------------------------------------------------
//  IDLE        | no game; waiting for start
//  TURN        | current player may request; frame_ticks count to forfeit
//  CHECK       | one cycle: legality of latched request against walls/opp
//  WAIT_FRAME  | legal target held until the next frame_tick
//  COMMIT      | mover takes target; win test or hand turn over
//  WON         | positions frozen, winner shown; start begins a new game
module ctf_turn_ctrl
    import ctf_turn_ctrl_pkg::*;
#(
    parameter int N           = 10,
    parameter int TURN_FRAMES = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 start,
    ctf_turn_ctrl_if.slave       hs,
    input  logic [N:0]           row1,
    input  logic [N:0]           row2,
    input  logic [N:0]           row3,
    input  logic [N:0]           row4,
    input  logic [N:0]           row5,
    input  logic [N:0]           row6,
    input  logic [N:0]           row7,
    input  logic [N:0]           row8,
    input  logic [N:0]           row9,
    input  logic [N:0]           row10,
    output logic [3:0]           b_x1,
    output logic [3:0]           b_y1,
    output logic [3:0]           b_x2,
    output logic [3:0]           b_y2,
    output logic                 turn,
    output logic                 move_rejected,
    output logic                 game_over,
    output logic [1:0]           winner
);

    localparam int CW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TURN_FRAMES - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    dir_q;
    logic [3:0]    tgt_x_q;
    logic [3:0]    tgt_y_q;

    logic       reload;
    logic       accept;
    logic       cnt_inc;
    logic       forfeit;
    logic       latch_tgt;
    logic       commit;

    logic       cur_valid;
    logic [1:0] cur_dir;
    logic [3:0] chk_x;
    logic [3:0] chk_y;
    logic       chk_legal;

    logic [3:0] p1n_x;
    logic [3:0] p1n_y;
    logic [3:0] p2n_x;
    logic [3:0] p2n_y;
    logic       win_p1;
    logic       win_p2;
    logic       win;

    assign cur_valid = turn ? hs.p2_valid : hs.p1_valid;
    assign cur_dir   = turn ? hs.p2_dir   : hs.p1_dir;

    ctf_turn_ctrl_move_check #(.N(N)) u_move_check (
        .pos_x (turn ? b_x2 : b_x1),
        .pos_y (turn ? b_y2 : b_y1),
        .dir   (dir_q),
        .opp_x (turn ? b_x1 : b_x2),
        .opp_y (turn ? b_y1 : b_y2),
        .row1  (row1),
        .row2  (row2),
        .row3  (row3),
        .row4  (row4),
        .row5  (row5),
        .row6  (row6),
        .row7  (row7),
        .row8  (row8),
        .row9  (row9),
        .row10 (row10),
        .tgt_x (chk_x),
        .tgt_y (chk_y),
        .legal (chk_legal)
    );

    // positions as they will be after the commit, for the win test
    assign p1n_x  = turn ? b_x1 : tgt_x_q;
    assign p1n_y  = turn ? b_y1 : tgt_y_q;
    assign p2n_x  = turn ? tgt_x_q : b_x2;
    assign p2n_y  = turn ? tgt_y_q : b_y2;
    assign win_p1 = (p1n_x == P1_GOAL_X) && (p1n_y == P1_GOAL_Y);
    assign win_p2 = (p2n_x == P2_GOAL_X) && (p2n_y == P2_GOAL_Y);
    assign win    = win_p1 || win_p2;

    assign game_over = (state_q == ST_WON);

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, handshake readies and datapath strobes
    always_comb begin
        state_d       = state_q;
        hs.p1_ready   = 1'b0;
        hs.p2_ready   = 1'b0;
        move_rejected = 1'b0;
        reload        = 1'b0;
        accept        = 1'b0;
        cnt_inc       = 1'b0;
        forfeit       = 1'b0;
        latch_tgt     = 1'b0;
        commit        = 1'b0;
        case (state_q)
            ST_IDLE, ST_WON: begin
                if (start) begin
                    reload  = 1'b1;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                hs.p1_ready = !turn;
                hs.p2_ready = turn;
                // an accept in the same cycle as the last tick beats the forfeit
                if (cur_valid) begin
                    accept  = 1'b1;
                    state_d = ST_CHECK;
                end else if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        forfeit = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (chk_legal) begin
                    latch_tgt = 1'b1;
                    state_d   = ST_WAIT_FRAME;
                end else begin
                    move_rejected = 1'b1;
                    state_d       = ST_TURN;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_tick) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = win ? ST_WON : ST_TURN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // positions, turn, forfeit counter, latched request and winner
    always_ff @(posedge clk) begin
        if (!reset) begin
            b_x1    <= P1_START_X;
            b_y1    <= P1_START_Y;
            b_x2    <= P2_START_X;
            b_y2    <= P2_START_Y;
            turn    <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            tgt_x_q <= '0;
            tgt_y_q <= '0;
            winner  <= WIN_NONE;
        end else begin
            if (reload) begin
                b_x1   <= P1_START_X;
                b_y1   <= P1_START_Y;
                b_x2   <= P2_START_X;
                b_y2   <= P2_START_Y;
                turn   <= 1'b0;
                cnt_q  <= '0;
                winner <= WIN_NONE;
            end
            if (accept) begin
                dir_q <= cur_dir;
                cnt_q <= '0;
            end
            if (cnt_inc) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (forfeit) begin
                turn  <= ~turn;
                cnt_q <= '0;
            end
            if (latch_tgt) begin
                tgt_x_q <= chk_x;
                tgt_y_q <= chk_y;
            end
            if (commit) begin
                if (turn) begin
                    b_x2 <= tgt_x_q;
                    b_y2 <= tgt_y_q;
                end else begin
                    b_x1 <= tgt_x_q;
                    b_y1 <= tgt_y_q;
                end
                if (win) begin
                    winner <= win_p1 ? WIN_P1 : WIN_P2;
                end else begin
                    turn <= ~turn;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctf_turn_ctrl.sv
// Bench for ctf_turn_ctrl: directed scenarios with literal expectations,
// then randomized play checked every cycle against a behavioural game model.
module tb_ctf_turn_ctrl;

    localparam int N  = 10;
    localparam int TF = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_TURN  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_WAIT  = 3;
    localparam int PH_MOVE  = 4;
    localparam int PH_OVER  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic [N:0]  rows [10];
    logic [3:0]  b_x1, b_y1, b_x2, b_y2;
    logic        turn, move_rejected, game_over;
    logic [1:0]  winner;

    int tests = 0;
    int fails = 0;

    ctf_turn_ctrl_if hs ();

    ctf_turn_ctrl #(.N(N), .TURN_FRAMES(TF)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .start         (start),
        .hs            (hs),
        .row1          (rows[0]),
        .row2          (rows[1]),
        .row3          (rows[2]),
        .row4          (rows[3]),
        .row5          (rows[4]),
        .row6          (rows[5]),
        .row7          (rows[6]),
        .row8          (rows[7]),
        .row9          (rows[8]),
        .row10         (rows[9]),
        .b_x1          (b_x1),
        .b_y1          (b_y1),
        .b_x2          (b_x2),
        .b_y2          (b_y2),
        .turn          (turn),
        .move_rejected (move_rejected),
        .game_over     (game_over),
        .winner        (winner)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural game model ----------------
    int m_ph = PH_IDLE;
    int mx [2];
    int my [2];
    int m_turn = 0;
    int m_frames = 0;
    int m_dir = 0;
    int m_tx = 0;
    int m_ty = 0;
    int m_win = 0;
    bit chk_en = 1'b0;

    function automatic bit m_legal(input int p, input int d, output int tx, output int ty);
        int dx = 0;
        int dy = 0;
        case (d)
            0:       dy = -1;
            1:       dy = 1;
            2:       dx = -1;
            default: dx = 1;
        endcase
        tx = mx[p] + dx;
        ty = my[p] + dy;
        if (tx < 0 || tx > 9 || ty < 0 || ty > 9) return 1'b0;
        if (rows[ty][tx] == 1'b1) return 1'b0;
        if (tx == mx[1-p] && ty == my[1-p]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_new_game();
        mx[0] = 0; my[0] = 0;
        mx[1] = 9; my[1] = 9;
        m_turn = 0;
        m_frames = 0;
        m_win = 0;
    endfunction

    always @(posedge clk) begin
        int tx, ty;
        bit v;
        if (!reset) begin
            m_new_game();
            m_ph = PH_IDLE;
            chk_en = 1'b1;
        end else begin
            case (m_ph)
                PH_IDLE, PH_OVER: begin
                    if (start) begin
                        m_new_game();
                        m_ph = PH_TURN;
                    end
                end
                PH_TURN: begin
                    v = (m_turn == 0) ? hs.p1_valid : hs.p2_valid;
                    if (v) begin
                        m_dir = (m_turn == 0) ? int'(hs.p1_dir) : int'(hs.p2_dir);
                        m_frames = 0;
                        m_ph = PH_CHECK;
                    end else if (frame_tick) begin
                        m_frames++;
                        if (m_frames == TF) begin
                            m_turn = 1 - m_turn;
                            m_frames = 0;
                        end
                    end
                end
                PH_CHECK: begin
                    if (m_legal(m_turn, m_dir, tx, ty)) begin
                        m_tx = tx;
                        m_ty = ty;
                        m_ph = PH_WAIT;
                    end else begin
                        m_ph = PH_TURN;
                    end
                end
                PH_WAIT: if (frame_tick) m_ph = PH_MOVE;
                default: begin
                    mx[m_turn] = m_tx;
                    my[m_turn] = m_ty;
                    if (mx[0] == 9 && my[0] == 9) begin
                        m_win = 1;
                        m_ph = PH_OVER;
                    end else if (mx[1] == 0 && my[1] == 0) begin
                        m_win = 2;
                        m_ph = PH_OVER;
                    end else begin
                        m_turn = 1 - m_turn;
                        m_ph = PH_TURN;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        int tx, ty;
        bit exp_rej;
        if (chk_en) begin
            exp_rej = (m_ph == PH_CHECK) && !m_legal(m_turn, m_dir, tx, ty);
            check("positions", {b_x1, b_y1, b_x2, b_y2},
                  {4'(mx[0]), 4'(my[0]), 4'(mx[1]), 4'(my[1])});
            check("turn", 16'(turn), 16'(m_turn));
            check("readies", 16'({hs.p1_ready, hs.p2_ready}),
                  16'({m_ph == PH_TURN && m_turn == 0, m_ph == PH_TURN && m_turn == 1}));
            check("move_rejected", 16'(move_rejected), 16'(exp_rej));
            check("game_over", 16'(game_over), 16'(m_ph == PH_OVER));
            check("winner", 16'(winner), 16'(m_win));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic play(input int p, input int d);
        int n = 0;
        while (((p == 0) ? !hs.p1_ready : !hs.p2_ready) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL play_ready_timeout: player %0d never ready", p + 1);
            return;
        end
        if (p == 0) begin
            hs.p1_valid = 1'b1;
            hs.p1_dir   = 2'(d);
        end else begin
            hs.p2_valid = 1'b1;
            hs.p2_dir   = 2'(d);
        end
        step();
        hs.p1_valid = 1'b0;
        hs.p2_valid = 1'b0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hs.p1_valid = 1'b0;
        hs.p1_dir   = 2'd0;
        hs.p2_valid = 1'b0;
        hs.p2_dir   = 2'd0;
        for (int y = 0; y < 10; y++) rows[y] = '0;

        // reset and start
        reset = 1'b0;
        repeat (3) step();
        check("rst_pos", {b_x1, b_y1, b_x2, b_y2}, 16'h0099);
        check("rst_ready", 16'({hs.p1_ready, hs.p2_ready}), 16'd0);
        check("rst_winner", 16'(winner), 16'd0);
        reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_turn", 16'(turn), 16'd0);
        check("start_ready", 16'({hs.p1_ready, hs.p2_ready}), 16'b10);

        // off-board move, then wall move
        hs.p1_valid = 1'b1; hs.p1_dir = 2'd0;
        step();
        hs.p1_valid = 1'b0;
        check("rej_up_pulse", 16'(move_rejected), 16'd1);
        step();
        check("rej_up_end", 16'(move_rejected), 16'd0);
        check("rej_up_turn", 16'(turn), 16'd0);
        check("rej_up_pos", {b_x1, b_y1}, 16'h00);
        rows[0][1] = 1'b1;
        hs.p1_valid = 1'b1; hs.p1_dir = 2'd3;
        step();
        hs.p1_valid = 1'b0;
        check("rej_wall_pulse", 16'(move_rejected), 16'd1);
        step();
        rows[0] = '0;

        // legal move held until a frame arrives
        hs.p1_valid = 1'b1; hs.p1_dir = 2'd3;
        step();
        hs.p1_valid = 1'b0;
        step();
        repeat (50) step();
        check("wait_no_frame", 16'(b_x1), 16'd0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("commit_cycle", 16'(b_x1), 16'd0);
        step();
        check("moved_x1", 16'(b_x1), 16'd1);
        check("moved_turn", 16'(turn), 16'd1);

        // forfeit after TF idle frames
        tick_frame();
        tick_frame();
        check("forfeit_not_yet", 16'(turn), 16'd1);
        tick_frame();
        check("forfeit_turn", 16'(turn), 16'd0);
        check("forfeit_ready", 16'({hs.p1_ready, hs.p2_ready}), 16'b10);

        // march P1 to (9,8) while P2 shuffles on row 9, then win
        for (int i = 1; i <= 16; i++) begin
            play(0, (i <= 8) ? 3 : 1);
            play(1, ((i % 2) == 1 || i == 16) ? 2 : 3);
        end
        check("pre_win_pos", {b_x1, b_y1, b_x2, b_y2}, 16'h9879);
        play(0, 1);
        check("win_pos", {b_x1, b_y1}, 16'h99);
        check("win_winner", 16'(winner), 16'd1);
        check("win_over", 16'(game_over), 16'd1);
        check("win_ready", 16'({hs.p1_ready, hs.p2_ready}), 16'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_pos", {b_x1, b_y1, b_x2, b_y2}, 16'h0099);
        check("restart_winner", 16'(winner), 16'd0);
        check("restart_over", 16'(game_over), 16'd0);

        // accept and forfeit-tick in the same cycle: accept wins
        tick_frame();
        tick_frame();
        hs.p1_valid = 1'b1; hs.p1_dir = 2'd3;
        frame_tick = 1'b1;
        step();
        hs.p1_valid = 1'b0;
        frame_tick = 1'b0;
        check("race_turn", 16'(turn), 16'd0);
        step();
        tick_frame();
        check("race_moved", 16'(b_x1), 16'd1);
        check("race_turn_after", 16'(turn), 16'd1);

        // reset during WAIT_FRAME discards the pending move
        hs.p2_valid = 1'b1; hs.p2_dir = 2'd2;
        step();
        hs.p2_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rst_wait_pos", {b_x1, b_y1, b_x2, b_y2}, 16'h0099);
        check("rst_wait_turn", 16'(turn), 16'd0);
        tick_frame();
        step();
        check("rst_wait_discard", {b_x2, b_y2}, 16'h99);
        check("rst_wait_idle", 16'({hs.p1_ready, hs.p2_ready}), 16'd0);

        // randomized play
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            hs.p1_valid = ($urandom_range(0, 3) == 0);
            hs.p1_dir   = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3)
                                                     : 2'($urandom_range(0, 3));
            hs.p2_valid = ($urandom_range(0, 3) == 0);
            hs.p2_dir   = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2)
                                                     : 2'($urandom_range(0, 3));
            frame_tick  = ($urandom_range(0, 4) == 0);
            start       = ($urandom_range(0, 80) == 0);
            reset       = ($urandom_range(0, 900) != 0);
            if ($urandom_range(0, 20) == 0) begin
                for (int y = 0; y < 10; y++) rows[y] = 11'($urandom & $urandom & $urandom);
            end
            step();
        end
        reset = 1'b1;
        start = 1'b0;
        frame_tick = 1'b0;
        hs.p1_valid = 1'b0;
        hs.p2_valid = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
